// File: rtl/alu_issue_sched_if.sv
// Request/issue/result bundle between the reservation-station slots and the ALU issue scheduler.
interface alu_issue_sched_if #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 6
);
    localparam int SEL_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*TAG_W-1:0] req_tag;
    logic [NREQ-1:0]       req_ready;
    logic                  stall;
    logic                  flush;
    logic                  alu_en;
    logic [SEL_W-1:0]      alu_sel;
    logic                  res_valid;
    logic [TAG_W-1:0]      res_tag;
    logic [31:0]           issue_count;
    logic [31:0]           conflict_count;

    modport master (
        output req_valid, req_tag, stall, flush,
        input  req_ready, alu_en, alu_sel, res_valid, res_tag, issue_count, conflict_count
    );

    modport slave (
        input  req_valid, req_tag, stall, flush,
        output req_ready, alu_en, alu_sel, res_valid, res_tag, issue_count, conflict_count
    );
endinterface

// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler for one ALU shared by NREQ reservation-station slots.
// Optional performance counters are built only when ALU_SCHED_PERF_EN is defined.
module alu_issue_sched #(
    parameter int NREQ  = 4,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_sched_if.slave bus
);
    localparam int SEL_W = $clog2(NREQ);

    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptr_nxt_s;
    logic [SEL_W-1:0] sel_s;
    logic [NREQ-1:0]  grant_s;
    logic             found_s;
    logic             issue_s;
    logic             multi_s;
    logic [SEL_W:0]   sum_s;
    logic [SEL_W-1:0] cand_s;
    logic             res_valid_r;
    logic [TAG_W-1:0] res_tag_r;

    // Round-robin search starting at ptr, first valid slot wins
    always_comb begin
        grant_s = '0;
        sel_s   = '0;
        found_s = 1'b0;
        sum_s   = '0;
        cand_s  = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum_s = {1'b0, ptr_r} + (SEL_W+1)'(k);
            if (sum_s >= (SEL_W+1)'(NREQ)) begin
                sum_s = sum_s - (SEL_W+1)'(NREQ);
            end else begin
                sum_s = sum_s;
            end
            cand_s = sum_s[SEL_W-1:0];
            if (!found_s && bus.req_valid[cand_s]) begin
                found_s        = 1'b1;
                sel_s          = cand_s;
                grant_s[cand_s] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Issue qualification, pointer advance and conflict detection
    always_comb begin
        issue_s = found_s && !rst && !bus.stall && !bus.flush;
        multi_s = ($countones(bus.req_valid) > 1) && !rst && !bus.stall && !bus.flush;
        if (sel_s == SEL_W'(NREQ - 1)) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = sel_s + SEL_W'(1);
        end
    end

    assign bus.req_ready = issue_s ? grant_s : '0;
    assign bus.alu_en    = issue_s;
    assign bus.alu_sel   = issue_s ? sel_s : '0;
    assign bus.res_valid = res_valid_r;
    assign bus.res_tag   = res_tag_r;

    // Arbitration pointer and result-tag pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r       <= '0;
            res_valid_r <= 1'b0;
            res_tag_r   <= '0;
        end else begin
            res_valid_r <= issue_s;
            if (issue_s) begin
                ptr_r     <= ptr_nxt_s;
                res_tag_r <= bus.req_tag[sel_s*TAG_W +: TAG_W];
            end else begin
                ptr_r     <= ptr_r;
                res_tag_r <= res_tag_r;
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    logic [31:0] issue_cnt_r;
    logic [31:0] conflict_cnt_r;

    // Free-running wrap-around performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt_r    <= 32'd0;
            conflict_cnt_r <= 32'd0;
        end else begin
            issue_cnt_r    <= issue_s ? issue_cnt_r + 32'd1 : issue_cnt_r;
            conflict_cnt_r <= multi_s ? conflict_cnt_r + 32'd1 : conflict_cnt_r;
        end
    end

    assign bus.issue_count    = issue_cnt_r;
    assign bus.conflict_count = conflict_cnt_r;
`else
    assign bus.issue_count    = 32'd0;
    assign bus.conflict_count = 32'd0;
`endif
endmodule

// File: tb/tb_alu_issue_sched.sv
// Self-checking bench for alu_issue_sched against a behavioural round-robin model.
module tb_alu_issue_sched;
    localparam int N  = 4;
    localparam int TW = 6;
`ifdef ALU_SCHED_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_issue_sched_if #(.NREQ(N), .TAG_W(TW)) bus ();
    alu_issue_sched #(.NREQ(N), .TAG_W(TW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [TW-1:0] tags [N];
    logic [N-1:0]  cur_v;
    logic          cur_st, cur_fl;

    // reference model state
    int            m_ptr;
    logic          m_rv;
    logic [TW-1:0] m_rt;
    int unsigned   m_ic, m_cc;

    function automatic int m_pick(logic [N-1:0] v, logic st, logic fl, logic r);
        if (r || st || fl) return -1;
        for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (((v >> idx) & 4'b0001) != 4'b0000) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(int p);
        return (p >= 0) ? (4'b0001 << p) : 4'b0000;
    endfunction

    function automatic logic [1:0] exp_sel(int p);
        return (p >= 0) ? 2'(p) : 2'd0;
    endfunction

    function automatic logic [31:0] exp_ic();
        return PERF ? 32'(m_ic) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_cc();
        return PERF ? 32'(m_cc) : 32'd0;
    endfunction

    task automatic m_reset();
        m_ptr = 0; m_rv = 1'b0; m_rt = '0; m_ic = 0; m_cc = 0;
    endtask

    task automatic m_edge();
        int p = m_pick(cur_v, cur_st, cur_fl, rst);
        if (rst) begin
            m_reset();
        end else begin
            if (p >= 0) begin
                m_rv = 1'b1; m_rt = tags[p]; m_ptr = (p + 1) % N; m_ic++;
            end else begin
                m_rv = 1'b0;
            end
            if ($countones(cur_v) >= 2 && !cur_st && !cur_fl) m_cc++;
        end
    endtask

    task automatic drive(logic [N-1:0] v, logic st, logic fl);
        cur_v = v; cur_st = st; cur_fl = fl;
        bus.req_valid = v;
        bus.stall     = st;
        bus.flush     = fl;
        bus.req_tag   = {tags[3], tags[2], tags[1], tags[0]};
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1; m_reset();
        drive(4'b0000, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        for (int j = 0; j < N; j++) tags[j] = TW'(j + 5);
        drive(4'b1111, 1'b0, 1'b0);
        m_reset();
        #1;
        total_cnt++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", bus.req_ready); else pass_cnt++;
        total_cnt++; if (bus.alu_en !== 1'b0) $display("FAIL reset_alu_en got %b want 0", bus.alu_en); else pass_cnt++;
        total_cnt++; if (bus.alu_sel !== 2'd0) $display("FAIL reset_alu_sel got %0d want 0", bus.alu_sel); else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL reset_res_valid got %b want 0", bus.res_valid); else pass_cnt++;
        total_cnt++; if (bus.res_tag !== 6'd0) $display("FAIL reset_res_tag got %h want 00", bus.res_tag); else pass_cnt++;
        total_cnt++; if (bus.issue_count !== 32'd0 || bus.conflict_count !== 32'd0)
            $display("FAIL reset_counts got %0d/%0d want 0/0", bus.issue_count, bus.conflict_count); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        int p;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < N; j++) tags[j] = TW'($urandom);
            drive(4'b1111, 1'b0, 1'b0);
            #1;
            p = m_pick(cur_v, cur_st, cur_fl, rst);
            total_cnt++; if (bus.alu_sel !== 2'(i)) $display("FAIL rr_sel cyc %0d got %0d want %0d", i, bus.alu_sel, i); else pass_cnt++;
            total_cnt++; if (bus.req_ready !== exp_ready(p) || bus.alu_en !== 1'b1)
                $display("FAIL rr_grant cyc %0d got %b/%b want %b/1", i, bus.req_ready, bus.alu_en, exp_ready(p)); else pass_cnt++;
            @(posedge clk); m_edge(); #1;
            total_cnt++; if (bus.res_valid !== 1'b1 || bus.res_tag !== tags[i])
                $display("FAIL rr_result cyc %0d got %b/%h want 1/%h", i, bus.res_valid, bus.res_tag, tags[i]); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_ptr_wrap();
        logic [N-1:0] seq [3] = '{4'b0010, 4'b0011, 4'b0011};
        int p;
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < N; j++) tags[j] = TW'($urandom);
            drive(seq[i], 1'b0, 1'b0);
            #1;
            p = m_pick(cur_v, cur_st, cur_fl, rst);
            total_cnt++; if (bus.req_ready !== exp_ready(p) || bus.alu_sel !== exp_sel(p))
                $display("FAIL wrap_grant cyc %0d got %b/%0d want %b/%0d", i, bus.req_ready, bus.alu_sel, exp_ready(p), exp_sel(p)); else pass_cnt++;
            total_cnt++; if (bus.req_ready[3:2] !== 2'b00) $display("FAIL wrap_upper cyc %0d got %b want 00", i, bus.req_ready[3:2]); else pass_cnt++;
            @(posedge clk); m_edge(); #1;
            total_cnt++; if (bus.res_valid !== m_rv || (m_rv && bus.res_tag !== m_rt))
                $display("FAIL wrap_result cyc %0d got %b/%h want %b/%h", i, bus.res_valid, bus.res_tag, m_rv, m_rt); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_stall_flush();
        // {valid, stall, flush}
        logic [5:0] seq [9] = '{
            {4'b0100, 1'b1, 1'b0}, {4'b0100, 1'b1, 1'b0}, {4'b0100, 1'b1, 1'b0},
            {4'b0100, 1'b0, 1'b0}, {4'b0010, 1'b0, 1'b1}, {4'b0110, 1'b1, 1'b1},
            {4'b0000, 1'b0, 1'b0}, {4'b0011, 1'b0, 1'b0}, {4'b1111, 1'b0, 1'b0}};
        int p;
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            for (int j = 0; j < N; j++) tags[j] = TW'($urandom);
            tags[1] = 6'h2A;
            drive(seq[i][5:2], seq[i][1], seq[i][0]);
            #1;
            p = m_pick(cur_v, cur_st, cur_fl, rst);
            total_cnt++; if (bus.req_ready !== exp_ready(p) || bus.alu_en !== (p >= 0) || bus.alu_sel !== exp_sel(p))
                $display("FAIL sf_grant cyc %0d got %b/%b/%0d want %b/%b/%0d", i, bus.req_ready, bus.alu_en, bus.alu_sel,
                         exp_ready(p), (p >= 0), exp_sel(p)); else pass_cnt++;
            @(posedge clk); m_edge(); #1;
            total_cnt++; if (bus.res_valid !== m_rv || (m_rv && bus.res_tag !== m_rt))
                $display("FAIL sf_result cyc %0d got %b/%h want %b/%h", i, bus.res_valid, bus.res_tag, m_rv, m_rt); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        for (int j = 0; j < N; j++) tags[j] = TW'($urandom);
        drive(4'b0010, 1'b0, 1'b0);
        @(posedge clk); m_edge(); #1;
        total_cnt++; if (bus.res_valid !== 1'b1) $display("FAIL mid_issue got %b want 1", bus.res_valid); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1; m_reset();
        drive(4'b1111, 1'b0, 1'b0);
        #1;
        total_cnt++; if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'b0000 || bus.alu_en !== 1'b0)
            $display("FAIL mid_in_reset got %b/%b/%b want 0/0000/0", bus.res_valid, bus.req_ready, bus.alu_en); else pass_cnt++;
        @(posedge clk); m_edge();
        @(negedge clk);
        rst = 1'b0;
        drive(4'b0000, 1'b0, 1'b0);
        @(posedge clk); m_edge(); #1;
        total_cnt++; if (bus.res_valid !== 1'b0) $display("FAIL mid_no_pulse got %b want 0", bus.res_valid); else pass_cnt++;
        @(negedge clk);
        drive(4'b1111, 1'b0, 1'b0);
        #1;
        total_cnt++; if (bus.alu_sel !== 2'd0 || bus.req_ready !== 4'b0001)
            $display("FAIL mid_ptr got %0d/%b want 0/0001", bus.alu_sel, bus.req_ready); else pass_cnt++;
        @(posedge clk); m_edge();
        @(negedge clk);
    endtask

    task automatic test_perf();
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < N; j++) tags[j] = TW'($urandom);
            drive(4'b1010, 1'b0, 1'b0);
            @(posedge clk); m_edge();
            @(negedge clk);
        end
        drive(4'b0000, 1'b0, 1'b0);
        #1;
        total_cnt++; if (bus.issue_count !== (PERF ? 32'd10 : 32'd0))
            $display("FAIL perf_issue got %0d want %0d", bus.issue_count, PERF ? 10 : 0); else pass_cnt++;
        total_cnt++; if (bus.conflict_count !== (PERF ? 32'd10 : 32'd0))
            $display("FAIL perf_conflict got %0d want %0d", bus.conflict_count, PERF ? 10 : 0); else pass_cnt++;
    endtask

    task automatic test_random();
        int p;
        reset_dut();
        for (int i = 0; i < 300; i++) begin
            for (int j = 0; j < N; j++) tags[j] = TW'($urandom);
            drive(4'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0));
            #1;
            p = m_pick(cur_v, cur_st, cur_fl, rst);
            total_cnt++; if (bus.req_ready !== exp_ready(p) || bus.alu_en !== (p >= 0) || bus.alu_sel !== exp_sel(p))
                $display("FAIL rnd_grant cyc %0d got %b/%b/%0d want %b/%b/%0d", i, bus.req_ready, bus.alu_en, bus.alu_sel,
                         exp_ready(p), (p >= 0), exp_sel(p)); else pass_cnt++;
            @(posedge clk); m_edge(); #1;
            total_cnt++; if (bus.res_valid !== m_rv || (m_rv && bus.res_tag !== m_rt))
                $display("FAIL rnd_result cyc %0d got %b/%h want %b/%h", i, bus.res_valid, bus.res_tag, m_rv, m_rt); else pass_cnt++;
            total_cnt++; if (bus.issue_count !== exp_ic() || bus.conflict_count !== exp_cc())
                $display("FAIL rnd_counts cyc %0d got %0d/%0d want %0d/%0d", i, bus.issue_count, bus.conflict_count,
                         exp_ic(), exp_cc()); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_ptr_wrap();
        test_stall_flush();
        test_reset_mid();
        test_perf();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
